// File: rtl/biu_arb_if.sv
// rtl/biu_arb_if.sv - BIU arbiter bundle: two requester ports plus the single BIU master port
package biu_arb_pkg;
   typedef logic [2:0] biu_size_t;
   typedef enum logic [2:0] {
      BIU_SINGLE = 3'd0,
      BIU_INCR   = 3'd1,
      BIU_WRAP4  = 3'd2,
      BIU_INCR4  = 3'd3,
      BIU_WRAP8  = 3'd4,
      BIU_INCR8  = 3'd5,
      BIU_WRAP16 = 3'd6,
      BIU_INCR16 = 3'd7
   } biu_type_t;
   typedef logic [3:0] biu_prot_t;
endpackage

interface biu_arb_if #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = DATA_SIZE
) ();
   // requester side, index 0 = data, 1 = instruction
   logic [1:0]                s_stb_i;
   logic [1:0]                s_stb_ack_o;
   logic [1:0]                s_d_ack_o;
   logic [ADDR_SIZE-1:0]      s_adri_i [2];
   biu_arb_pkg::biu_size_t    s_size_i [2];
   biu_arb_pkg::biu_type_t    s_type_i [2];
   biu_arb_pkg::biu_prot_t    s_prot_i [2];
   logic [1:0]                s_lock_i;
   logic [1:0]                s_we_i;
   logic [DATA_SIZE-1:0]      s_d_i [2];
   logic [DATA_SIZE-1:0]      s_q_o;
   logic [1:0]                s_ack_o;
   logic [1:0]                s_err_o;

   // BIU side
   logic                      m_stb_o;
   logic [ADDR_SIZE-1:0]      m_adri_o;
   biu_arb_pkg::biu_size_t    m_size_o;
   biu_arb_pkg::biu_type_t    m_type_o;
   biu_arb_pkg::biu_prot_t    m_prot_o;
   logic                      m_lock_o;
   logic                      m_we_o;
   logic [DATA_SIZE-1:0]      m_d_o;
   logic                      m_stb_ack_i;
   logic                      m_d_ack_i;
   logic [DATA_SIZE-1:0]      m_q_i;
   logic                      m_ack_i;
   logic                      m_err_i;

   modport slave (
      input  s_stb_i, s_adri_i, s_size_i, s_type_i, s_prot_i, s_lock_i, s_we_i, s_d_i,
      output s_stb_ack_o, s_d_ack_o, s_q_o, s_ack_o, s_err_o,
      output m_stb_o, m_adri_o, m_size_o, m_type_o, m_prot_o, m_lock_o, m_we_o, m_d_o,
      input  m_stb_ack_i, m_d_ack_i, m_q_i, m_ack_i, m_err_i
   );

   modport master (
      output s_stb_i, s_adri_i, s_size_i, s_type_i, s_prot_i, s_lock_i, s_we_i, s_d_i,
      input  s_stb_ack_o, s_d_ack_o, s_q_o, s_ack_o, s_err_o,
      input  m_stb_o, m_adri_o, m_size_o, m_type_o, m_prot_o, m_lock_o, m_we_o, m_d_o,
      output m_stb_ack_i, m_d_ack_i, m_q_i, m_ack_i, m_err_i
   );
endinterface

// File: rtl/biu_arb.sv
// rtl/biu_arb.sv - two-port round-robin BIU arbiter with pipelined same-owner requests and locking
module biu_arb
   import biu_arb_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = DATA_SIZE
) (
   input  logic      HCLK,
   input  logic      HRESETn,
   biu_arb_if.slave  bus
);

   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       locked_q, locked_d;
   logic [5:0] pend_q, pend_d;

   logic                 sel;
   logic                 stb_w;
   logic                 grant;
   logic [4:0]           beats;
   logic [6:0]           sum;
   logic [ADDR_SIZE-1:0] adri_w;
   logic [DATA_SIZE-1:0] d_w;
   logic [DATA_SIZE-1:0] q_w;

   function automatic logic [4:0] beats_of(input biu_type_t t);
      case (t)
         BIU_WRAP4,  BIU_INCR4:  return 5'd4;
         BIU_WRAP8,  BIU_INCR8:  return 5'd8;
         BIU_WRAP16, BIU_INCR16: return 5'd16;
         default:                return 5'd1;
      endcase
   endfunction

   // Ownership may only move while nothing is outstanding and no lock is held.
   always_comb begin
      sel = owner_q;
      if (pend_q == 6'd0 && !locked_q) begin
         if (&bus.s_stb_i)        sel = ~last_q;
         else if (bus.s_stb_i[1]) sel = 1'b1;
         else if (bus.s_stb_i[0]) sel = 1'b0;
      end
   end

   assign stb_w = bus.s_stb_i[sel]
                & ((pend_q == 6'd0) | (sel == owner_q))
                & ~(locked_q & (sel != owner_q));
   assign grant = bus.m_stb_ack_i & stb_w;
   assign beats = beats_of(bus.s_type_i[sel]);

   assign adri_w       = bus.s_adri_i[sel];
   assign d_w          = bus.s_d_i[sel];
   assign q_w          = bus.m_q_i;
   assign bus.m_stb_o  = stb_w;
   assign bus.m_adri_o = adri_w;
   assign bus.m_size_o = bus.s_size_i[sel];
   assign bus.m_type_o = bus.s_type_i[sel];
   assign bus.m_prot_o = bus.s_prot_i[sel];
   assign bus.m_lock_o = bus.s_lock_i[sel];
   assign bus.m_we_o   = bus.s_we_i[sel];
   assign bus.m_d_o    = d_w;
   assign bus.s_q_o    = q_w;

   assign bus.s_stb_ack_o = {grant & sel, grant & ~sel};
   assign bus.s_ack_o     = {bus.m_ack_i   & owner_q, bus.m_ack_i   & ~owner_q};
   assign bus.s_err_o     = {bus.m_err_i   & owner_q, bus.m_err_i   & ~owner_q};
   assign bus.s_d_ack_o   = {bus.m_d_ack_i & owner_q, bus.m_d_ack_i & ~owner_q};

   always_comb begin
      owner_d  = owner_q;
      last_d   = last_q;
      locked_d = locked_q;
      sum      = {1'b0, pend_q} + (grant ? {2'b00, beats} : 7'd0);
      if (bus.m_ack_i && sum != 7'd0) sum = sum - 7'd1;

      // An error aborts the whole outstanding sequence, whatever else happens this cycle.
      if (bus.m_err_i)       pend_d = 6'd0;
      else if (sum > 7'd63)  pend_d = 6'd63;
      else                   pend_d = sum[5:0];

      if (locked_q && !bus.s_lock_i[owner_q] && pend_q == 6'd0) locked_d = 1'b0;
      if (grant && bus.s_lock_i[sel])                            locked_d = 1'b1;

      if (grant) begin
         owner_d = sel;
         last_d  = sel;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         locked_q <= 1'b0;
         pend_q   <= 6'd0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         locked_q <= locked_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: tb/tb_biu_arb.sv
// tb/tb_biu_arb.sv - directed scenarios plus randomized traffic checked against a behavioural arbiter model
module tb_biu_arb;
   import biu_arb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;

   always #5 HCLK = ~HCLK;

   biu_arb_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

   biu_arb #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   int md_owner, md_last, md_locked, md_pend;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int beats_of(input biu_type_t t);
      int tbl[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
      return tbl[int'(t)];
   endfunction

   task automatic model_reset();
      md_owner  = 0;
      md_last   = 1;
      md_locked = 0;
      md_pend   = 0;
   endtask

   function automatic int model_sel();
      int s = md_owner;
      if (md_pend == 0 && md_locked == 0) begin
         if (bus.s_stb_i == 2'b11)      s = 1 - md_last;
         else if (bus.s_stb_i == 2'b10) s = 1;
         else if (bus.s_stb_i == 2'b01) s = 0;
      end
      return s;
   endfunction

   task automatic drive(input logic [1:0] stb, input biu_type_t t0, input biu_type_t t1,
                        input logic [1:0] lk, input logic sa, input logic ack, input logic err);
      bus.s_stb_i     = stb;
      bus.s_type_i[0] = t0;
      bus.s_type_i[1] = t1;
      bus.s_lock_i    = lk;
      bus.m_stb_ack_i = sa;
      bus.m_ack_i     = ack;
      bus.m_err_i     = err;
      bus.m_d_ack_i   = 1'($urandom_range(0, 1));
      bus.m_q_i       = $urandom;
      bus.s_we_i      = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
         bus.s_adri_i[p] = $urandom;
         bus.s_d_i[p]    = $urandom;
         bus.s_size_i[p] = 3'($urandom);
         bus.s_prot_i[p] = 4'($urandom);
      end
   endtask

   // Checks every output against the model, advances the model, ends on the next falling edge.
   task automatic tick();
      int         s;
      bit         st, g;
      int         np;
      logic [1:0] own, gv;
      #1;
      s   = model_sel();
      st  = bus.s_stb_i[s] && (md_pend == 0 || s == md_owner) && !(md_locked != 0 && s != md_owner);
      g   = st && bus.m_stb_ack_i;
      own = (md_owner == 1) ? 2'b10 : 2'b01;
      gv  = !g ? 2'b00 : ((s == 1) ? 2'b10 : 2'b01);
      chk("pend", dut.pend_q, md_pend);
      chk("m_stb_o", bus.m_stb_o, st);
      chk("s_stb_ack_o", bus.s_stb_ack_o, gv);
      chk("s_ack_o", bus.s_ack_o, bus.m_ack_i ? own : 2'b00);
      chk("s_err_o", bus.s_err_o, bus.m_err_i ? own : 2'b00);
      chk("s_d_ack_o", bus.s_d_ack_o, bus.m_d_ack_i ? own : 2'b00);
      chk("s_q_o", bus.s_q_o, bus.m_q_i);
      chk("m_adri_o", bus.m_adri_o, bus.s_adri_i[s]);
      chk("m_d_o", bus.m_d_o, bus.s_d_i[s]);
      chk("m_ctl", {bus.m_we_o, bus.m_lock_o, bus.m_type_o, bus.m_size_o, bus.m_prot_o},
                   {bus.s_we_i[s], bus.s_lock_i[s], bus.s_type_i[s], bus.s_size_i[s], bus.s_prot_i[s]});
      if (HRESETn) begin
         np = md_pend + (g ? beats_of(bus.s_type_i[s]) : 0);
         if (bus.m_ack_i && np > 0) np--;
         if (bus.m_err_i) np = 0;
         if (np > 63) np = 63;
         if (md_locked != 0 && !bus.s_lock_i[md_owner] && md_pend == 0) md_locked = 0;
         if (g && bus.s_lock_i[s]) md_locked = 1;
         if (g) begin
            md_owner = s;
            md_last  = s;
         end
         md_pend = np;
      end else begin
         model_reset();
      end
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      chk("rst_pend", dut.pend_q, 0);
      chk("rst_stb_ack", bus.s_stb_ack_o, 2'b00);
      chk("rst_ack", bus.s_ack_o, 2'b00);
      chk("rst_err", bus.s_err_o, 2'b00);
      tick();
      HRESETn = 1'b1;

      // Tie after reset: port 0 first, port 1 once port 0 is acked.
      drive(2'b11, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("tie_p0", bus.s_stb_ack_o, 2'b01);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b1, 1'b0);
      #1 chk("tie_wait", bus.s_stb_ack_o, 2'b00);
      chk("tie_ack0", bus.s_ack_o, 2'b01);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("tie_p1", bus.s_stb_ack_o, 2'b10);
      tick();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
      #1 chk("tie_ack1", bus.s_ack_o, 2'b10);
      tick();

      // Port 1 INCR4 stalls port 0 until all four beats are acked.
      drive(2'b10, BIU_SINGLE, BIU_INCR4, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("b4_grant", bus.s_stb_ack_o, 2'b10);
      tick();
      chk("b4_pend", dut.pend_q, 4);
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b1, 1'b0);
         #1 chk("b4_stall", bus.m_stb_o, 1'b0);
         chk("b4_ack", bus.s_ack_o, 2'b10);
         tick();
      end
      chk("b4_drain", dut.pend_q, 0);
      drive(2'b01, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("b4_p0", bus.s_stb_ack_o, 2'b01);
      tick();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();

      // Port 0 pipelined singles.
      drive(2'b01, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("pipe_g1", bus.s_stb_ack_o, 2'b01);
      tick();
      chk("pipe_pend1", dut.pend_q, 1);
      drive(2'b01, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("pipe_g2", bus.s_stb_ack_o, 2'b01);
      tick();
      chk("pipe_pend2", dut.pend_q, 2);
      drive(2'b01, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b1, 1'b0);
      #1 chk("pipe_g3", bus.s_stb_ack_o, 2'b01);
      chk("pipe_ack", bus.s_ack_o, 2'b01);
      tick();
      chk("pipe_net", dut.pend_q, 2);
      for (int i = 0; i < 2; i++) begin
         drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
         #1 chk("pipe_ackn", bus.s_ack_o, 2'b01);
         tick();
      end

      // Error on beat 3 of a port 0 WRAP8, then port 1 goes.
      drive(2'b01, BIU_WRAP8, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("err_grant", bus.s_stb_ack_o, 2'b01);
      tick();
      chk("err_pend8", dut.pend_q, 8);
      for (int i = 0; i < 2; i++) begin
         drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b1, 1'b0);
         #1 chk("err_stall", bus.m_stb_o, 1'b0);
         tick();
      end
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b1);
      #1 chk("err_route", bus.s_err_o, 2'b01);
      tick();
      chk("err_clear", dut.pend_q, 0);
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("err_next", bus.s_stb_ack_o, 2'b10);
      tick();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();

      // Locked port 0 sequence holds off port 1.
      drive(2'b11, BIU_SINGLE, BIU_SINGLE, 2'b01, 1'b1, 1'b0, 1'b0);
      #1 chk("lk_g1", bus.s_stb_ack_o, 2'b01);
      tick();
      drive(2'b11, BIU_SINGLE, BIU_SINGLE, 2'b01, 1'b0, 1'b1, 1'b0);
      tick();
      drive(2'b11, BIU_SINGLE, BIU_SINGLE, 2'b01, 1'b1, 1'b0, 1'b0);
      #1 chk("lk_g2", bus.s_stb_ack_o, 2'b01);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b1, 1'b0);
      #1 chk("lk_hold", bus.m_stb_o, 1'b0);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("lk_release", bus.s_stb_ack_o, 2'b00);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("lk_p1", bus.s_stb_ack_o, 2'b10);
      tick();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();

      // Reset in the middle of a burst with five beats outstanding.
      drive(2'b10, BIU_SINGLE, BIU_INCR4, 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      drive(2'b10, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      chk("rst_pend5", dut.pend_q, 5);
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b0, 1'b0);
      HRESETn = 1'b0;
      model_reset();
      #1 chk("rst_mid_pend", dut.pend_q, 0);
      chk("rst_mid_ack", bus.s_ack_o, 2'b00);
      tick();
      tick();
      HRESETn = 1'b1;
      drive(2'b11, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 chk("rst_tie", bus.s_stb_ack_o, 2'b01);
      tick();
      drive(2'b00, BIU_SINGLE, BIU_SINGLE, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();

      // Randomized traffic; outstanding count kept within two 16-beat bursts.
      for (int i = 0; i < 400; i++) begin
         drive(2'($urandom),
               biu_type_t'($urandom_range(0, 7)),
               biu_type_t'($urandom_range(0, 7)),
               {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
               (md_pend <= 16) ? 1'($urandom_range(0, 1)) : 1'b0,
               (md_pend > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
               (md_pend > 0 && $urandom_range(0, 31) == 0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
